// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole judge.
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ARMED   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [7:0] BCD_MAX     = 8'h99;
    localparam logic [3:0] MISS_MAX    = 4'd15;
    localparam logic [3:0] STREAK_MAX  = 4'd15;
    // Prior streak at which a hit starts being worth two points.
    localparam logic [3:0] COMBO_START = 4'd2;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] max);
        return (v >= max) ? max : v + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_sat_add.sv
// Two-digit BCD adder for +1 or +2 that sticks at 99 instead of wrapping.
module bcd_sat_add
    import whack_pkg::*;
(
    input  logic [7:0] a,
    input  logic       add_two,
    output logic [7:0] sum
);

    logic [4:0] units;
    logic [4:0] tens;
    logic       carry;

    always_comb begin
        units = {1'b0, a[3:0]} + (add_two ? 5'd2 : 5'd1);
        carry = 1'b0;
        if (units > 5'd9) begin
            units = units - 5'd10;
            carry = 1'b1;
        end
        tens = {1'b0, a[7:4]} + {4'd0, carry};
        if ((a >= BCD_MAX) || (tens > 5'd9)) begin
            sum = BCD_MAX;
        end else begin
            sum = {tens[3:0], units[3:0]};
        end
    end

endmodule

// File: rtl/whack_judge.sv
// Judges button presses against the raised mole; keeps BCD score, misses and streak.
// Define WHACK_COMBO_EN to enable streak tracking and double points from the 3rd hit on.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | game stopped, counters hold, cleared on next enable
// ST_WAIT    | waiting for a mole to be raised
// ST_ARMED   | mole latched, judging presses
// ST_LOCKOUT | penalty after a wrong press, presses ignored
module whack_judge
    import whack_pkg::*;
#(
    parameter int HOLES       = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             game_en_i,
    input  logic [HOLES-1:0] mole_i,
    input  logic             mole_valid_i,
    input  logic [HOLES-1:0] hit_i,
    output logic [7:0]       score_o,
    output logic [3:0]       miss_o,
    output logic             hit_o,
    output logic             wrong_o,
    output logic             clear_o,
    output logic [3:0]       streak_o
);

    localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [HOLES-1:0] mole_q, mole_d;
    logic [7:0]       lock_q, lock_d;
    logic [7:0]       score_q, score_d;
    logic [3:0]       miss_q, miss_d;
    logic [3:0]       streak_q, streak_d;
    logic             hit_q, hit_d;
    logic             wrong_q, wrong_d;
    logic             clear_q, clear_d;

    logic             press;
    logic             press_match;
    logic             add_two;
    logic [3:0]       streak_hit;
    logic [7:0]       score_sum;

    assign press       = |hit_i;
    assign press_match = press && (hit_i == mole_q);

`ifdef WHACK_COMBO_EN
    assign add_two    = (streak_q >= COMBO_START);
    assign streak_hit = sat_inc4(streak_q, STREAK_MAX);
`else
    assign add_two    = 1'b0;
    assign streak_hit = 4'd0;
`endif

    bcd_sat_add u_bcd_sat_add (
        .a       (score_q),
        .add_two (add_two),
        .sum     (score_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mole_q   <= '0;
            lock_q   <= 8'd0;
            score_q  <= 8'h00;
            miss_q   <= 4'd0;
            streak_q <= 4'd0;
            hit_q    <= 1'b0;
            wrong_q  <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mole_q   <= mole_d;
            lock_q   <= lock_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
            streak_q <= streak_d;
            hit_q    <= hit_d;
            wrong_q  <= wrong_d;
            clear_q  <= clear_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mole_d   = mole_q;
        lock_d   = lock_q;
        score_d  = score_q;
        miss_d   = miss_q;
        streak_d = streak_q;
        hit_d    = 1'b0;
        wrong_d  = 1'b0;
        clear_d  = 1'b0;

        // Disabling the game overrides any judgement in the same cycle.
        if (!game_en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    score_d  = 8'h00;
                    miss_d   = 4'd0;
                    streak_d = 4'd0;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (mole_valid_i) begin
                        mole_d  = mole_i;
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (press_match) begin
                        score_d  = score_sum;
                        streak_d = streak_hit;
                        hit_d    = 1'b1;
                        clear_d  = 1'b1;
                        state_d  = ST_WAIT;
                    end else if (press) begin
                        wrong_d  = 1'b1;
                        miss_d   = sat_inc4(miss_q, MISS_MAX);
                        streak_d = 4'd0;
                        lock_d   = LOCK_LOAD;
                        state_d  = ST_LOCKOUT;
                    end else if (!mole_valid_i) begin
                        miss_d   = sat_inc4(miss_q, MISS_MAX);
                        streak_d = 4'd0;
                        state_d  = ST_WAIT;
                    end
                end
                ST_LOCKOUT: begin
                    if (lock_q == 8'd0) begin
                        state_d = mole_valid_i ? ST_ARMED : ST_WAIT;
                    end else begin
                        lock_d = lock_q - 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign score_o  = score_q;
    assign miss_o   = miss_q;
    assign streak_o = streak_q;
    assign hit_o    = hit_q;
    assign wrong_o  = wrong_q;
    assign clear_o  = clear_q;

endmodule

// File: tb/tb_whack_judge.sv
// Self-checking bench for whack_judge against a cycle-level game model.
module tb_whack_judge;

    localparam int HOLES       = 8;
    localparam int LOCK_CYCLES = 16;
`ifdef WHACK_COMBO_EN
    localparam bit COMBO = 1'b1;
`else
    localparam bit COMBO = 1'b0;
`endif

    localparam int PH_IDLE   = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_ARMED  = 2;
    localparam int PH_LOCKED = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             game_en_i;
    logic [HOLES-1:0] mole_i;
    logic             mole_valid_i;
    logic [HOLES-1:0] hit_i;
    logic [7:0]       score_o;
    logic [3:0]       miss_o;
    logic             hit_o;
    logic             wrong_o;
    logic             clear_o;
    logic [3:0]       streak_o;

    int checks   = 0;
    int failures = 0;

    int         m_phase;
    int         m_score;
    int         m_miss;
    int         m_streak;
    int         m_lock;
    logic [7:0] m_mole;
    logic       m_hit;
    logic       m_wrong;
    logic       m_clear;

    whack_judge #(.HOLES(HOLES), .LOCK_CYCLES(LOCK_CYCLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .game_en_i    (game_en_i),
        .mole_i       (mole_i),
        .mole_valid_i (mole_valid_i),
        .hit_i        (hit_i),
        .score_o      (score_o),
        .miss_o       (miss_o),
        .hit_o        (hit_o),
        .wrong_o      (wrong_o),
        .clear_o      (clear_o),
        .streak_o     (streak_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_score  = 0;
        m_miss   = 0;
        m_streak = 0;
        m_lock   = 0;
        m_mole   = 8'h00;
        m_hit    = 1'b0;
        m_wrong  = 1'b0;
        m_clear  = 1'b0;
    endtask

    // One clock: the model judges the inputs seen at the edge, outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        m_hit   = 1'b0;
        m_wrong = 1'b0;
        m_clear = 1'b0;
        if (rst) begin
            model_reset();
        end else if (!game_en_i) begin
            m_phase = PH_IDLE;
        end else if (m_phase == PH_IDLE) begin
            m_score  = 0;
            m_miss   = 0;
            m_streak = 0;
            m_phase  = PH_WAIT;
        end else if (m_phase == PH_WAIT) begin
            if (mole_valid_i) begin
                m_mole  = mole_i;
                m_phase = PH_ARMED;
            end
        end else if (m_phase == PH_ARMED) begin
            if (hit_i != 0 && hit_i == m_mole) begin
                m_score = m_score + ((COMBO && m_streak >= 2) ? 2 : 1);
                if (m_score > 99) m_score = 99;
                if (COMBO && m_streak < 15) m_streak = m_streak + 1;
                m_hit   = 1'b1;
                m_clear = 1'b1;
                m_phase = PH_WAIT;
            end else if (hit_i != 0) begin
                m_wrong  = 1'b1;
                if (m_miss < 15) m_miss = m_miss + 1;
                m_streak = 0;
                m_lock   = LOCK_CYCLES;
                m_phase  = PH_LOCKED;
            end else if (!mole_valid_i) begin
                if (m_miss < 15) m_miss = m_miss + 1;
                m_streak = 0;
                m_phase  = PH_WAIT;
            end
        end else begin
            m_lock = m_lock - 1;
            if (m_lock == 0) m_phase = mole_valid_i ? PH_ARMED : PH_WAIT;
        end
        #1;
    endtask

    task automatic restart_game();
        hit_i        = 8'h00;
        mole_valid_i = 1'b0;
        game_en_i    = 1'b0;
        step();
        game_en_i = 1'b1;
        step();
    endtask

    task automatic arm(input logic [7:0] m);
        mole_i       = m;
        mole_valid_i = 1'b1;
        hit_i        = 8'h00;
        step();
    endtask

    task automatic press(input logic [7:0] h);
        hit_i = h;
        step();
        hit_i = 8'h00;
    endtask

    task automatic escape();
        mole_valid_i = 1'b0;
        hit_i        = 8'h00;
        step();
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        game_en_i    = 1'b0;
        mole_i       = 8'h00;
        mole_valid_i = 1'b0;
        hit_i        = 8'h00;
        model_reset();
        #2;
        checks++;
        if ({score_o, miss_o, streak_o, hit_o, wrong_o, clear_o} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got score=%h miss=%0d streak=%0d pulses=%b%b%b want all zero",
                     score_o, miss_o, streak_o, hit_o, wrong_o, clear_o);
        end
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (dut.state_q !== whack_pkg::ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got %0d want IDLE", dut.state_q);
        end
    endtask

    task automatic test_correct_hit();
        restart_game();
        arm(8'b0000_0100);
        press(8'b0000_0100);
        checks++;
        if (hit_o !== 1'b1 || clear_o !== 1'b1 || score_o !== 8'h01 || wrong_o !== 1'b0) begin
            failures++;
            $display("FAIL correct_hit got hit=%b clear=%b wrong=%b score=%h want 1 1 0 01",
                     hit_o, clear_o, wrong_o, score_o);
        end
        step();
        checks++;
        if (hit_o !== 1'b0 || clear_o !== 1'b0) begin
            failures++;
            $display("FAIL hit_pulse_width got hit=%b clear=%b want 0 0", hit_o, clear_o);
        end
    endtask

    task automatic test_wrong_lockout();
        logic [7:0] score_before;
        // Previous test left the mole raised, so the judge is armed on bit 2 again.
        checks++;
        if (m_phase != PH_ARMED) begin
            failures++;
            $display("FAIL wrong_setup got phase=%0d want armed", m_phase);
        end
        score_before = score_o;
        press(8'b0000_1000);
        checks++;
        if (wrong_o !== 1'b1 || miss_o !== 4'd1 || hit_o !== 1'b0) begin
            failures++;
            $display("FAIL wrong_press got wrong=%b miss=%0d hit=%b want 1 1 0", wrong_o, miss_o, hit_o);
        end
        for (int i = 1; i <= 4; i++) step();
        press(8'b0000_0100);
        checks++;
        if (hit_o !== 1'b0 || score_o !== score_before) begin
            failures++;
            $display("FAIL lockout_ignore got hit=%b score=%h want 0 %h", hit_o, score_o, score_before);
        end
        for (int i = 6; i <= 15; i++) step();
        press(8'b0000_0100);
        checks++;
        if (hit_o !== 1'b0 || wrong_o !== 1'b0) begin
            failures++;
            $display("FAIL lockout_last_cycle got hit=%b wrong=%b want 0 0", hit_o, wrong_o);
        end
        press(8'b0000_0100);
        checks++;
        if (hit_o !== 1'b1 || score_o !== to_bcd(m_score) || miss_o !== 4'd1) begin
            failures++;
            $display("FAIL lockout_resume got hit=%b score=%h miss=%0d want 1 %h 1",
                     hit_o, score_o, miss_o, to_bcd(m_score));
        end
    endtask

    task automatic test_bcd_carry_sat();
        int inc;
        restart_game();
        while (m_score < 9) begin
            inc = (COMBO && m_streak >= 2) ? 2 : 1;
            arm(8'b0001_0000);
            if (m_score + inc > 9) escape();
            else press(8'b0001_0000);
        end
        checks++;
        if (score_o !== 8'h09) begin
            failures++;
            $display("FAIL bcd_nine got score=%h want 09", score_o);
        end
        arm(8'b0001_0000);
        press(8'b0001_0000);
        checks++;
        if (score_o !== to_bcd(m_score) || score_o[3:0] > 4'd9) begin
            failures++;
            $display("FAIL bcd_carry got score=%h want %h", score_o, to_bcd(m_score));
        end
`ifndef WHACK_COMBO_EN
        checks++;
        if (score_o !== 8'h10) begin
            failures++;
            $display("FAIL bcd_carry_literal got score=%h want 10", score_o);
        end
`endif
        while (m_score < 99) begin
            arm(8'b1000_0000);
            press(8'b1000_0000);
        end
        checks++;
        if (score_o !== 8'h99) begin
            failures++;
            $display("FAIL bcd_reach_99 got score=%h want 99", score_o);
        end
        arm(8'b1000_0000);
        press(8'b1000_0000);
        checks++;
        if (score_o !== 8'h99 || hit_o !== 1'b1) begin
            failures++;
            $display("FAIL bcd_saturate got score=%h hit=%b want 99 1", score_o, hit_o);
        end
    endtask

    task automatic test_hit_vs_drop();
        logic [3:0] miss_before;
        restart_game();
        arm(8'b0000_0010);
        miss_before  = miss_o;
        mole_valid_i = 1'b0;
        press(8'b0000_0010);
        checks++;
        if (hit_o !== 1'b1 || miss_o !== miss_before || score_o !== 8'h01) begin
            failures++;
            $display("FAIL hit_beats_drop got hit=%b miss=%0d score=%h want 1 %0d 01",
                     hit_o, miss_o, score_o, miss_before);
        end
        arm(8'b0000_0010);
        escape();
        checks++;
        if (miss_o !== miss_before + 4'd1 || hit_o !== 1'b0 || wrong_o !== 1'b0 || clear_o !== 1'b0) begin
            failures++;
            $display("FAIL escape_miss got miss=%0d pulses=%b%b%b want %0d 000",
                     miss_o, hit_o, wrong_o, clear_o, miss_before + 4'd1);
        end
    endtask

    task automatic test_miss_saturate();
        restart_game();
        for (int i = 0; i < 17; i++) begin
            arm(8'b0100_0000);
            escape();
        end
        checks++;
        if (miss_o !== 4'd15 || streak_o !== 4'd0) begin
            failures++;
            $display("FAIL miss_saturate got miss=%0d streak=%0d want 15 0", miss_o, streak_o);
        end
    endtask

    task automatic test_combo();
        logic [7:0] want_score [3];
        logic [3:0] want_streak;
`ifdef WHACK_COMBO_EN
        want_score[0] = 8'h01; want_score[1] = 8'h02; want_score[2] = 8'h04;
        want_streak   = 4'd3;
`else
        want_score[0] = 8'h01; want_score[1] = 8'h02; want_score[2] = 8'h03;
        want_streak   = 4'd0;
`endif
        restart_game();
        for (int i = 0; i < 3; i++) begin
            arm(8'b0010_0000);
            press(8'b0010_0000);
            checks++;
            if (score_o !== want_score[i] || score_o !== to_bcd(m_score)) begin
                failures++;
                $display("FAIL combo_score hit %0d got %h want %h", i, score_o, want_score[i]);
            end
        end
        checks++;
        if (streak_o !== want_streak) begin
            failures++;
            $display("FAIL combo_streak got %0d want %0d", streak_o, want_streak);
        end
        arm(8'b0010_0000);
        escape();
        checks++;
        if (streak_o !== 4'd0 || miss_o !== 4'd1) begin
            failures++;
            $display("FAIL combo_escape got streak=%0d miss=%0d want 0 1", streak_o, miss_o);
        end
    endtask

    task automatic test_game_disable();
        logic [7:0] score_before;
        logic [3:0] miss_before;
        restart_game();
        arm(8'b0000_0001);
        press(8'b0000_0001);
        arm(8'b0000_0001);
        score_before = score_o;
        miss_before  = miss_o;
        game_en_i    = 1'b0;
        step();
        press(8'b0000_0001);
        checks++;
        if (score_o !== score_before || miss_o !== miss_before || hit_o !== 1'b0 || wrong_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got score=%h miss=%0d hit=%b wrong=%b want %h %0d 0 0",
                     score_o, miss_o, hit_o, wrong_o, score_before, miss_before);
        end
        game_en_i = 1'b1;
        step();
        checks++;
        if (score_o !== 8'h00 || miss_o !== 4'd0 || streak_o !== 4'd0) begin
            failures++;
            $display("FAIL restart_clear got score=%h miss=%0d streak=%0d want 00 0 0",
                     score_o, miss_o, streak_o);
        end
    endtask

    task automatic test_rst_lockout();
        restart_game();
        arm(8'b0000_0100);
        press(8'b0000_0011);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({score_o, miss_o, streak_o, hit_o, wrong_o, clear_o} !== 19'd0 ||
            dut.state_q !== whack_pkg::ST_IDLE) begin
            failures++;
            $display("FAIL rst_in_lockout got miss=%0d wrong=%b state=%0d want 0 0 IDLE",
                     miss_o, wrong_o, dut.state_q);
        end
        step();
        game_en_i    = 1'b1;
        mole_i       = 8'b0000_0100;
        mole_valid_i = 1'b1;
        hit_i        = 8'b0000_0100;
        rst          = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (hit_o !== 1'b0 || wrong_o !== 1'b0 || clear_o !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_pulse cycle %0d got pulses=%b%b%b want 000",
                         i, hit_o, wrong_o, clear_o);
            end
        end
        hit_i = 8'h00;
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 1500; n++) begin
            game_en_i    = ($urandom_range(0, 49) != 0);
            mole_valid_i = ($urandom_range(0, 6) != 0);
            mole_i       = 8'(1 << $urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r <= 5)      hit_i = 8'h00;
            else if (r <= 7) hit_i = m_mole;
            else if (r == 8) hit_i = 8'(1 << $urandom_range(0, 7));
            else             hit_i = 8'($urandom);
            step();
            checks++;
            if (score_o !== to_bcd(m_score) || miss_o !== 4'(m_miss) || streak_o !== 4'(m_streak) ||
                hit_o !== m_hit || wrong_o !== m_wrong || clear_o !== m_clear) begin
                failures++;
                $display("FAIL random cycle %0d got s=%h m=%0d k=%0d p=%b%b%b want s=%h m=%0d k=%0d p=%b%b%b",
                         n, score_o, miss_o, streak_o, hit_o, wrong_o, clear_o,
                         to_bcd(m_score), m_miss, m_streak, m_hit, m_wrong, m_clear);
            end
        end
        hit_i = 8'h00;
    endtask

    initial begin
        test_reset();
        test_correct_hit();
        test_wrong_lockout();
        test_bcd_carry_sat();
        test_hit_vs_drop();
        test_miss_saturate();
        test_combo();
        test_game_disable();
        test_rst_lockout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
